// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier feeding the accumulator write port.
// One multiply in flight at a time; start/busy/done handshake, done doubles as acc_write.
//
//   state  | meaning
//   IDLE   | waiting for start, operands captured on the accepting edge
//   RUN    | WIDTH add/shift steps, product registered on the last one
//   DONE   | one-cycle done/acc_write pulse, then back to IDLE
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 acc_write,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] partial_q, partial_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] sum;
    logic               last_step;

    // Sum including the current step, so the final edge can register the full product.
    assign sum       = partial_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            partial_q <= '0;
            product_q <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            partial_q <= partial_d;
            product_q <= product_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        partial_d = partial_q;
        product_d = product_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d   = {{WIDTH{1'b0}}, a};
                    mplier_d  = b;
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                partial_d = sum;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                if (last_step) begin
                    product_d = sum;
                    state_d   = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        acc_write = (state_q == S_DONE);
        product   = product_q;
    end

endmodule
